// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the 5-stage LEGv8 pipeline. Owns the program
// counter, issues one outstanding request at a time to instruction memory
// over a req/ack handshake, absorbs downstream stalls with a one-entry skid
// buffer, and redirects on branches resolved in the MEM stage while
// squashing any fetch that was already in flight.
//
// Ports
//   CLOCK          in   1   rising-edge clock
//   RESET          in   1   synchronous, active-high reset
//   stall          in   1   hazard unit: hold output, start no new fetch
//   isZeroBranch   in   1   EX/MEM: conditional (CBZ-style) branch
//   isUnconBranch  in   1   EX/MEM: unconditional branch
//   alu_zero       in   1   EX/MEM: ALU zero flag
//   shifted_PC     in  64   EX/MEM: branch target
//   imem_req       out  1   fetch request
//   imem_addr      out 64   fetch address, stable while imem_req is high
//   imem_ack       in   1   response valid (ignored while imem_req is low)
//   imem_data      in  32   fetched instruction, valid with imem_ack
//   PC_out         out 64   PC of the instruction in IC_out
//   IC_out         out 32   instruction to IF/ID
//   valid_out      out  1   IC_out holds a real instruction
//   flush_out      out  1   one-cycle pulse: squash younger stages
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F,
  parameter int unsigned PC_STEP   = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        stall,
  input  logic        isZeroBranch,
  input  logic        isUnconBranch,
  input  logic        alu_zero,
  input  logic [63:0] shifted_PC,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [63:0] PC_out,
  output logic [31:0] IC_out,
  output logic        valid_out,
  output logic        flush_out
);

  // IDLE : no request outstanding (after reset, or parked on a stalled ack)
  // REQ  : request outstanding, its response is wanted
  // DRAIN: request outstanding, its response is stale and will be dropped
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [63:0] STEP = 64'(PC_STEP);

  state_e      state_q,      state_d;
  logic [63:0] pc_q,         pc_d;
  logic [63:0] req_addr_q,   req_addr_d;
  logic [63:0] pc_out_q,     pc_out_d;
  logic [31:0] ic_out_q,     ic_out_d;
  logic        valid_out_q,  valid_out_d;
  logic        flush_q,      flush_d;
  logic [63:0] skid_pc_q,    skid_pc_d;
  logic [31:0] skid_ic_q,    skid_ic_d;
  logic        skid_valid_q, skid_valid_d;

  logic        redirect;
  logic        req_active;
  logic [63:0] req_addr_next;

  assign redirect      = (isZeroBranch & alu_zero) | isUnconBranch;
  assign req_active    = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign req_addr_next = req_addr_q + STEP;  // wraps modulo 2^64

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path
    // through this block can leave one unassigned and infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    pc_out_d     = pc_out_q;
    ic_out_d     = ic_out_q;
    valid_out_d  = valid_out_q;
    flush_d      = 1'b0;
    skid_pc_d    = skid_pc_q;
    skid_ic_d    = skid_ic_q;
    skid_valid_d = skid_valid_q;

    if (redirect) begin
      // Redirect wins over stall: the skid entry and the current output are
      // both younger than the branch, so they are dropped. PC_out is held.
      pc_d         = shifted_PC;
      skid_valid_d = 1'b0;
      valid_out_d  = 1'b0;
      ic_out_d     = NOP_INSTR;
      flush_d      = 1'b1;
      if (req_active && !imem_ack) begin
        // Memory still owes us a response for req_addr; keep asking for the
        // same address until it arrives, then throw it away.
        state_d = ST_DRAIN;
      end else begin
        // Nothing outstanding after this edge (any same-cycle ack is
        // discarded), so the target can be requested right away.
        state_d    = ST_REQ;
        req_addr_d = shifted_PC;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!stall) begin
            if (skid_valid_q) begin
              pc_out_d     = skid_pc_q;
              ic_out_d     = skid_ic_q;
              valid_out_d  = 1'b1;
              skid_valid_d = 1'b0;
            end else begin
              valid_out_d = 1'b0;
              ic_out_d    = NOP_INSTR;
            end
            req_addr_d = pc_q;
            state_d    = ST_REQ;
          end
        end

        ST_REQ: begin
          if (imem_ack) begin
            pc_d = req_addr_next;
            if (!stall) begin
              pc_out_d    = req_addr_q;
              ic_out_d    = imem_data;
              valid_out_d = 1'b1;
              req_addr_d  = req_addr_next;
            end else begin
              // Output is frozen; park the response in the skid entry and
              // stop issuing until the stall releases. The skid is always
              // empty here because requests only start from IDLE after it
              // has been drained.
              skid_pc_d    = req_addr_q;
              skid_ic_d    = imem_data;
              skid_valid_d = 1'b1;
              state_d      = ST_IDLE;
            end
          end else if (!stall) begin
            valid_out_d = 1'b0;
            ic_out_d    = NOP_INSTR;
          end
        end

        ST_DRAIN: begin
          // Output is already a bubble from the redirect that got us here.
          if (imem_ack) begin
            req_addr_d = pc_q;
            state_d    = ST_REQ;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of order.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      pc_out_q     <= RESET_PC;
      ic_out_q     <= NOP_INSTR;
      valid_out_q  <= 1'b0;
      flush_q      <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      pc_out_q     <= pc_out_d;
      ic_out_q     <= ic_out_d;
      valid_out_q  <= valid_out_d;
      flush_q      <= flush_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // NOTE: the skid payload is qualified by skid_valid_q and is never read
  // while invalid, so it is left out of reset to save reset fan-out.
  always_ff @(posedge CLOCK) begin
    skid_pc_q <= skid_pc_d;
    skid_ic_q <= skid_ic_d;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign imem_req  = req_active;
  assign imem_addr = req_addr_q;
  assign PC_out    = pc_out_q;
  assign IC_out    = ic_out_q;
  assign valid_out = valid_out_q;
  assign flush_out = flush_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Directed scenarios followed by a randomized run. All expected values come
// from a transaction-level reference model: an "outstanding request" flag, a
// "response is stale" flag and a queue standing in for the skid buffer.
// Inputs change and outputs are compared on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;
  localparam logic [63:0] STEP      = 64'd4;

  logic        CLOCK;
  logic        RESET;
  logic        stall;
  logic        isZeroBranch;
  logic        isUnconBranch;
  logic        alu_zero;
  logic [63:0] shifted_PC;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [63:0] PC_out;
  logic [31:0] IC_out;
  logic        valid_out;
  logic        flush_out;

  if_fetch_stage dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .stall        (stall),
    .isZeroBranch (isZeroBranch),
    .isUnconBranch(isUnconBranch),
    .alu_zero     (alu_zero),
    .shifted_PC   (shifted_PC),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .PC_out       (PC_out),
    .IC_out       (IC_out),
    .valid_out    (valid_out),
    .flush_out    (flush_out)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32];
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] pc;
    logic [31:0] ic;
  } entry_t;

  bit          m_known = 0;
  bit          m_busy;      // a request is outstanding
  bit          m_stale;     // its response must be discarded
  logic [63:0] m_pc;        // next address to fetch
  logic [63:0] m_addr;      // address presented to memory
  logic [63:0] m_pc_out;
  logic [31:0] m_ic;
  bit          m_valid;
  bit          m_flush;
  entry_t      skid_q[$];

  task automatic model_bubble();
    m_valid = 0;
    m_ic    = NOP_INSTR;
  endtask

  task automatic model_update(input logic rst, input logic s, input logic rd,
                              input logic [63:0] tgt, input logic a);
    logic [31:0] word;
    entry_t      e;
    if (rst) begin
      m_known  = 1;
      m_busy   = 0;
      m_stale  = 0;
      m_pc     = RESET_PC;
      m_addr   = RESET_PC;
      m_pc_out = RESET_PC;
      m_ic     = NOP_INSTR;
      m_valid  = 0;
      m_flush  = 0;
      skid_q.delete();
    end else if (m_known) begin
      word    = mem_word(m_addr);
      m_flush = rd;
      if (rd) begin
        m_pc = tgt;
        skid_q.delete();
        model_bubble();
        if (m_busy && !a) begin
          m_stale = 1;
        end else begin
          m_busy  = 1;
          m_stale = 0;
          m_addr  = tgt;
        end
      end else if (!m_busy) begin
        if (!s) begin
          if (skid_q.size() > 0) begin
            e        = skid_q.pop_front();
            m_pc_out = e.pc;
            m_ic     = e.ic;
            m_valid  = 1;
          end else begin
            model_bubble();
          end
          m_addr = m_pc;
          m_busy = 1;
        end
      end else if (m_stale) begin
        if (a) begin
          m_addr  = m_pc;
          m_stale = 0;
        end
      end else if (a) begin
        if (!s) begin
          m_pc_out = m_addr;
          m_ic     = word;
          m_valid  = 1;
          m_addr   = m_addr + STEP;
          m_pc     = m_addr;
        end else begin
          e.pc = m_addr;
          e.ic = word;
          skid_q.push_back(e);
          m_pc   = m_addr + STEP;
          m_busy = 0;
        end
      end else if (!s) begin
        model_bubble();
      end
    end
  endtask

  task automatic compare_model();
    check("imem_req",  {63'd0, imem_req},  {63'd0, m_busy});
    check("imem_addr", imem_addr,          m_addr);
    check("PC_out",    PC_out,             m_pc_out);
    check("IC_out",    {32'd0, IC_out},    {32'd0, m_ic});
    check("valid_out", {63'd0, valid_out}, {63'd0, m_valid});
    check("flush_out", {63'd0, flush_out}, {63'd0, m_flush});
  endtask

  // One clock: compare current outputs, apply inputs, advance the model,
  // then wait for the next falling edge.
  task automatic step(input logic rst, input logic s, input logic zb, input logic ub,
                      input logic az, input logic [63:0] tgt, input logic a);
    if (m_known) compare_model();
    RESET         = rst;
    stall         = s;
    isZeroBranch  = zb;
    isUnconBranch = ub;
    alu_zero      = az;
    shifted_PC    = tgt;
    imem_ack      = a;
    imem_data     = mem_word(imem_addr);
    model_update(rst, s, (zb & az) | ub, tgt, a);
    @(negedge CLOCK);
  endtask

  // Shorthand for a plain cycle with no branch and no reset.
  task automatic run(input logic s, input logic a);
    step(1'b0, s, 1'b0, 1'b0, 1'b0, 64'h0, a);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; stall = 1'b0; isZeroBranch = 1'b0; isUnconBranch = 1'b0;
    alu_zero = 1'b0; shifted_PC = 64'h0; imem_ack = 1'b0; imem_data = 32'h0;
    @(negedge CLOCK);

    // Reset, then stream with a zero-wait memory.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    check("rst_req",   {63'd0, imem_req},  64'd0);
    check("rst_pc",    PC_out,             64'h0);
    check("rst_ic",    {32'd0, IC_out},    {32'd0, NOP_INSTR});
    check("rst_valid", {63'd0, valid_out}, 64'd0);
    check("rst_flush", {63'd0, flush_out}, 64'd0);
    run(1'b0, 1'b1);
    check("first_req",  {63'd0, imem_req}, 64'd1);
    check("first_addr", imem_addr,         64'h0);
    run(1'b0, 1'b1);
    check("stream_pc0", PC_out,            64'h0);
    check("stream_v0",  {63'd0, valid_out}, 64'd1);
    run(1'b0, 1'b1);
    check("stream_pc4", PC_out,            64'h4);
    check("stream_ic4", {32'd0, IC_out},   64'h4);

    // Stall exactly at the ack of address 8.
    run(1'b1, 1'b1);
    run(1'b1, 1'b0);
    run(1'b1, 1'b0);
    check("stall_hold_pc", PC_out,             64'h4);
    check("stall_no_req",  {63'd0, imem_req},  64'd0);
    run(1'b0, 1'b0);
    check("skid_out_pc",   PC_out,             64'h8);
    check("skid_out_ic",   {32'd0, IC_out},    64'h8);
    check("after_skid_addr", imem_addr,        64'hC);
    run(1'b0, 1'b1);
    check("after_skid_pc", PC_out,             64'hC);

    // Three wait states on address 0x10.
    repeat (3) begin
      run(1'b0, 1'b0);
      check("wait_addr",  imem_addr,           64'h10);
      check("wait_valid", {63'd0, valid_out},  64'd0);
      check("wait_ic",    {32'd0, IC_out},     {32'd0, NOP_INSTR});
    end
    run(1'b0, 1'b1);
    check("wait_done_pc", PC_out, 64'h10);
    repeat (3) run(1'b0, 1'b1);

    // Unconditional redirect while 0x20 is outstanding.
    run(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h100, 1'b0);
    check("drain_flush", {63'd0, flush_out}, 64'd1);
    check("drain_addr",  imem_addr,          64'h20);
    run(1'b0, 1'b0);
    check("drain_flush_once", {63'd0, flush_out}, 64'd0);
    check("drain_hold_addr",  imem_addr,          64'h20);
    run(1'b0, 1'b1);
    check("drain_next_addr",  imem_addr,          64'h100);
    check("drain_bubble",     {63'd0, valid_out}, 64'd0);
    run(1'b0, 1'b1);
    check("target_pc",        PC_out,             64'h100);

    // Conditional branch not taken, then taken with a same-cycle ack.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h40, 1'b1);
    check("cbz_nt_flush", {63'd0, flush_out}, 64'd0);
    check("cbz_nt_pc",    PC_out,             64'h104);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h40, 1'b1);
    check("cbz_t_flush",  {63'd0, flush_out}, 64'd1);
    check("cbz_t_addr",   imem_addr,          64'h40);
    check("cbz_t_pchold", PC_out,             64'h104);
    check("cbz_t_valid",  {63'd0, valid_out}, 64'd0);
    run(1'b0, 1'b1);
    check("cbz_t_pc",     PC_out,             64'h40);

    // Redirect while stalled with a full skid.
    run(1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h200, 1'b0);
    check("rs_valid", {63'd0, valid_out}, 64'd0);
    check("rs_req",   {63'd0, imem_req},  64'd1);
    check("rs_addr",  imem_addr,          64'h200);
    run(1'b0, 1'b1);
    check("rs_pc",    PC_out,             64'h200);

    // Reset while draining.
    run(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h300, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    check("rd_req",   {63'd0, imem_req},  64'd0);
    check("rd_addr",  imem_addr,          64'h0);
    check("rd_flush", {63'd0, flush_out}, 64'd0);
    check("rd_ic",    {32'd0, IC_out},    {32'd0, NOP_INSTR});

    // Randomized traffic, including targets near the top of the address space.
    for (int i = 0; i < 4000; i++) begin
      logic        r_rst, r_s, r_zb, r_ub, r_az, r_a;
      logic [63:0] r_tgt;
      r_rst = ($urandom_range(0, 299) == 0);
      r_s   = ($urandom_range(0, 3) == 0);
      r_zb  = ($urandom_range(0, 19) == 0);
      r_az  = $urandom_range(0, 1) == 1;
      r_ub  = ($urandom_range(0, 29) == 0);
      r_a   = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 3))
        0:       r_tgt = {$urandom, $urandom};
        1:       r_tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
        default: r_tgt = {32'h0, $urandom & 32'hFFFF_FFFC};
      endcase
      step(r_rst, r_s, r_zb, r_ub, r_az, r_tgt, r_a);
    end
    compare_model();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
